// File: rtl/instruction_fetch.sv
// RV32 fetch stage and IF/ID register: owns the PC, drives a req/ack instruction
// memory port, absorbs decode stalls in a one-entry skid buffer and flushes on redirect.
module instruction_fetch #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h00000000,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic [6:0]      if_opcode
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_HOLD,
      S_DROP
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_redirect_pc;
   logic [XLEN-1:0] r_skid_pc;
   logic [XLEN-1:0] r_skid_instr;
   logic            r_if_valid;
   logic [XLEN-1:0] r_if_pc;
   logic [XLEN-1:0] r_if_instr;

   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_pc_inc;
   logic [XLEN-1:0] w_if_instr;

   assign w_target = branch_target & ~XLEN'(3);
   assign w_pc_inc = r_pc + XLEN'(4);

   // The request is a pure function of the state register, so it never glitches.
   assign imem_req  = (r_state == S_FETCH) || (r_state == S_DROP);
   assign imem_addr = r_pc;

   assign w_if_instr = r_if_valid ? r_if_instr : NOP_INSTR;
   assign if_valid   = r_if_valid;
   assign if_pc      = r_if_pc;
   assign if_instr   = w_if_instr;
   assign if_opcode  = w_if_instr[6:0];

   // NOTE: all state updates use non-blocking assignments so every branch below
   // reads the pre-edge values of r_pc and r_if_valid, exactly like the hardware.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_redirect_pc <= RESET_PC;
         // NOTE: the skid entry is only read in S_HOLD, which reset leaves, so
         // clearing it is for clean waveforms rather than correctness.
         r_skid_pc     <= '0;
         r_skid_instr  <= NOP_INSTR;
         r_if_valid    <= 1'b0;
         r_if_pc       <= '0;
         r_if_instr    <= NOP_INSTR;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
            end

            S_FETCH: begin
               if (branch_taken && imem_ack) begin
                  r_pc       <= w_target;
                  r_if_valid <= 1'b0;
               end else if (branch_taken) begin
                  // The old request must complete before the new address may be driven.
                  r_redirect_pc <= w_target;
                  r_if_valid    <= 1'b0;
                  r_state       <= S_DROP;
               end else if (imem_ack && (!r_if_valid || !stall)) begin
                  r_if_valid <= 1'b1;
                  r_if_pc    <= r_pc;
                  r_if_instr <= imem_rdata;
                  r_pc       <= w_pc_inc;
               end else if (imem_ack) begin
                  r_skid_pc    <= r_pc;
                  r_skid_instr <= imem_rdata;
                  r_pc         <= w_pc_inc;
                  r_state      <= S_HOLD;
               end else if (!stall) begin
                  r_if_valid <= 1'b0;
               end
            end

            S_HOLD: begin
               if (branch_taken) begin
                  r_pc       <= w_target;
                  r_if_valid <= 1'b0;
                  r_state    <= S_FETCH;
               end else if (!stall) begin
                  r_if_valid <= 1'b1;
                  r_if_pc    <= r_skid_pc;
                  r_if_instr <= r_skid_instr;
                  r_state    <= S_FETCH;
               end
            end

            S_DROP: begin
               r_if_valid <= 1'b0;
               if (imem_ack) begin
                  // A redirect arriving with the ack is the youngest one and wins.
                  r_pc    <= branch_taken ? w_target : r_redirect_pc;
                  r_state <= S_FETCH;
               end else if (branch_taken) begin
                  r_redirect_pc <= w_target;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed-vector bench for instruction_fetch: a req/ack memory model with
// configurable latency and ack budget, and a scoreboard of expected decode PCs.
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] KEY = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [6:0]  if_opcode;

   int lat       = 0;
   int ack_limit = 0;
   int ack_count = 0;
   int wait_cnt  = 0;
   int n_checks  = 0;
   int n_errors  = 0;

   logic [31:0] sb_q[$];
   logic        pend      = 1'b0;
   logic [31:0] pend_addr = 32'h0;

   always #5 clk = ~clk;

   instruction_fetch #(
      .XLEN      (32),
      .RESET_PC  (32'h00000000),
      .NOP_INSTR (32'h00000013)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .if_opcode     (if_opcode)
   );

   // Memory model: acks after `lat` wait cycles, only while the ack budget allows.
   assign imem_ack   = imem_req && (ack_count < ack_limit) && (wait_cnt >= lat);
   assign imem_rdata = imem_addr ^ KEY;

   always @(posedge clk) begin
      if (imem_ack) ack_count <= ack_count + 1;
      if (rst || !imem_req || imem_ack) wait_cnt <= 0;
      else                              wait_cnt <= wait_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] opc(input logic [31:0] w);
      return w[6:0];
   endfunction

   // Monitor: decode consumes an instruction when it is valid, not stalled and not flushed.
   always @(negedge clk) begin
      if (pend) check("addr_stable", imem_addr, pend_addr);
      pend      <= !rst && imem_req && !imem_ack;
      pend_addr <= imem_addr;
      if (!rst && if_valid && !stall && !branch_taken) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_extra: got if_pc %h expected no instruction", if_pc);
         end else begin
            check("sb_pc", if_pc, sb_q[0]);
            check("sb_instr", if_instr, sb_q[0] ^ KEY);
            check("sb_opcode", {25'b0, if_opcode}, {25'b0, opc(sb_q[0] ^ KEY)});
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_reset();
      ack_limit    = ack_count;
      stall        = 1'b0;
      branch_taken = 1'b0;
      rst          = 1'b1;
      tick(2);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && sb_q.size() != 0; i++) tick();
      tick(4);
      check(name, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
      check({tag, "_pc"}, if_pc, 32'h0);
      check({tag, "_instr"}, if_instr, NOP);
      check({tag, "_opcode"}, {25'b0, if_opcode}, 32'h13);
      check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
      check({tag, "_addr"}, imem_addr, 32'h0);
   endtask

   initial begin
      // Zero-wait memory, no stall: one instruction per cycle.
      start_reset();
      check_reset_outputs("rst0");
      lat       = 0;
      ack_limit = ack_count + 5;
      for (int i = 0; i < 5; i++) sb_q.push_back(32'(i * 4));
      rst = 1'b0;
      tick();
      check("t1_first_req", {31'b0, imem_req}, 32'd1);
      check("t1_first_addr", imem_addr, 32'h0);
      check("t1_valid_c1", {31'b0, if_valid}, 32'd0);
      tick();
      check("t1_valid_c2", {31'b0, if_valid}, 32'd1);
      check("t1_pc_c2", if_pc, 32'h0);
      check("t1_addr_c2", imem_addr, 32'h4);
      tick();
      check("t1_pc_c3", if_pc, 32'h4);
      drain("t1_drain");

      // Two-cycle ack latency: address held three cycles, valid toggles 1,0,0.
      start_reset();
      lat       = 2;
      ack_limit = ack_count + 3;
      for (int i = 0; i < 3; i++) sb_q.push_back(32'(i * 4));
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_addr_hold", imem_addr, 32'h0);
      end
      tick();
      check("t2_valid_a", {31'b0, if_valid}, 32'd1);
      check("t2_addr_next", imem_addr, 32'h4);
      tick();
      check("t2_valid_b", {31'b0, if_valid}, 32'd0);
      tick();
      check("t2_valid_c", {31'b0, if_valid}, 32'd0);
      tick();
      check("t2_valid_d", {31'b0, if_valid}, 32'd1);
      check("t2_pc_d", if_pc, 32'h4);
      drain("t2_drain");

      // Stall while PC 8 is in IF/ID and the PC 12 ack arrives: skid, then replay.
      start_reset();
      lat       = 0;
      ack_limit = ack_count + 5;
      for (int i = 0; i < 5; i++) sb_q.push_back(32'(i * 4));
      rst = 1'b0;
      tick(4);
      check("t3_pc_pre", if_pc, 32'h8);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_hold_req", {31'b0, imem_req}, 32'd0);
         check("t3_hold_pc", if_pc, 32'h8);
         check("t3_hold_valid", {31'b0, if_valid}, 32'd1);
      end
      stall = 1'b0;
      tick();
      check("t3_skid_pc", if_pc, 32'hC);
      check("t3_skid_instr", if_instr, 32'hC ^ KEY);
      check("t3_resume_req", {31'b0, imem_req}, 32'd1);
      check("t3_resume_addr", imem_addr, 32'h10);
      drain("t3_drain");

      // Redirect during an ack-less request to 0x20, retargeted once while in DROP.
      start_reset();
      lat       = 0;
      ack_limit = ack_count + 8;
      for (int i = 0; i < 8; i++) sb_q.push_back(32'(i * 4));
      sb_q.push_back(32'h104);
      sb_q.push_back(32'h108);
      rst = 1'b0;
      tick(9);
      check("t4_pc_last", if_pc, 32'h1C);
      check("t4_addr_20", imem_addr, 32'h20);
      tick();
      check("t4_bubble", {31'b0, if_valid}, 32'd0);
      branch_taken  = 1'b1;
      branch_target = 32'h80;
      tick();
      check("t4_drop_req", {31'b0, imem_req}, 32'd1);
      check("t4_drop_addr", imem_addr, 32'h20);
      branch_target = 32'h104;
      tick();
      check("t4_drop_addr2", imem_addr, 32'h20);
      check("t4_drop_valid", {31'b0, if_valid}, 32'd0);
      branch_taken = 1'b0;
      ack_limit    = ack_count + 3;
      tick();
      check("t4_redirect_addr", imem_addr, 32'h104);
      check("t4_redirect_valid", {31'b0, if_valid}, 32'd0);
      tick();
      check("t4_load_valid", {31'b0, if_valid}, 32'd1);
      check("t4_load_pc", if_pc, 32'h104);
      drain("t4_drain");

      // Redirect to an unaligned target while in HOLD with stall still high.
      start_reset();
      lat       = 0;
      ack_limit = ack_count + 3;
      sb_q.push_back(32'h0);
      sb_q.push_back(32'h200);
      rst = 1'b0;
      tick(3);
      check("t5_pc_pre", if_pc, 32'h4);
      stall = 1'b1;
      tick();
      check("t5_hold_req", {31'b0, imem_req}, 32'd0);
      branch_taken  = 1'b1;
      branch_target = 32'h203;
      tick();
      check("t5_addr", imem_addr, 32'h200);
      check("t5_req", {31'b0, imem_req}, 32'd1);
      check("t5_valid", {31'b0, if_valid}, 32'd0);
      check("t5_nop", if_instr, NOP);
      branch_taken = 1'b0;
      stall        = 1'b0;
      ack_limit    = ack_count + 1;
      tick();
      check("t5_load_pc", if_pc, 32'h200);
      drain("t5_drain");

      // Reset while a request to 0x8 is outstanding and its ack lands in the reset cycle.
      start_reset();
      lat       = 0;
      ack_limit = ack_count + 2;
      sb_q.push_back(32'h0);
      sb_q.push_back(32'h4);
      rst = 1'b0;
      tick(4);
      check("t6_addr_pend", imem_addr, 32'h8);
      rst       = 1'b1;
      ack_limit = ack_count + 1;
      tick();
      check_reset_outputs("t6_rst");
      rst       = 1'b0;
      ack_limit = ack_count + 1;
      sb_q.push_back(32'h0);
      tick();
      check("t6_req", {31'b0, imem_req}, 32'd1);
      check("t6_addr", imem_addr, 32'h0);
      tick();
      check("t6_valid", {31'b0, if_valid}, 32'd1);
      check("t6_pc", if_pc, 32'h0);
      drain("t6_drain");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
